aib_sram_dma: RTL

- Sequential DMA engine that sits directly upstream of the AIB SRAM wrapper and drives its bus-side memory port (addr/write/wdata/wmask/read, 1-cycle read data).
- Write mode: moves a 32-bit valid/ready stream (AIB RX datapath) into consecutive SRAM words.
- Read mode: streams consecutive SRAM words out on a valid/ready master stream (AIB TX datapath).
- The bus memory port has priority over APB inside the wrapper, so the engine never stalls on memory.

---
 rtl/aib_sram_dma.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aib_sram_dma.sv
// Sequential DMA between a 32-bit valid/ready stream and the AIB SRAM bus port.
// Optional CRC-32 over transferred words is enabled by defining AIB_SRAM_DMA_CRC_EN.
module aib_sram_dma #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_count,
    output logic [31:0]       o_mem_addr,
    output logic              o_mem_write,
    output logic [31:0]       o_mem_wdata,
    output logic [31:0]       o_mem_wmask,
    output logic              o_mem_read,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [31:0]       i_s_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [31:0]       o_m_data,
    output logic [31:0]       o_crc
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

    localparam logic [LEN_W-1:0] ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] base_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  issued;
    logic              inflight;
    logic [1:0]        occ;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [31:0]       fifo_q [2];

    logic              wr_act;
    logic              rd_act;
    logic              m_valid_int;
    logic [31:0]       head;
    logic              pop;
    logic              push_store;
    logic              pop_fifo;
    logic [2:0]        level;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] mem_addr;
    logic              beat;

    // Read data from the previous cycle bypasses the FIFO when it is empty,
    // which gives the 2-cycle start-to-valid latency.
    always_comb begin
        wr_act      = (state == S_WR) && !i_abort;
        rd_act      = ((state == S_RD) || (state == S_DRAIN)) && !i_abort;
        o_s_ready   = wr_act;
        o_mem_write = wr_act && i_s_valid;
        m_valid_int = rd_act && ((occ != 2'd0) || inflight);
        head        = (occ != 2'd0) ? fifo_q[rd_ptr] : i_mem_rdata;
        pop         = m_valid_int && i_m_ready;
        push_store  = inflight && !(pop && (occ == 2'd0));
        pop_fifo    = pop && (occ != 2'd0);
        level       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        o_mem_read  = (state == S_RD) && !i_abort && (issued < len_r) && (level < 3'd2);
        offset      = o_mem_write ? count[ADDR_W-1:0] : issued[ADDR_W-1:0];
        mem_addr    = base_r + offset;
        o_mem_addr  = (o_mem_write || o_mem_read) ? {{(32-ADDR_W){1'b0}}, mem_addr} : 32'd0;
        o_mem_wdata = o_mem_write ? i_s_data : 32'd0;
        o_mem_wmask = o_mem_write ? 32'hFFFF_FFFF : 32'd0;
        o_m_valid   = m_valid_int;
        o_m_data    = m_valid_int ? head : 32'd0;
        beat        = o_mem_write || pop;
        o_busy      = (state != S_IDLE);
        o_done      = (state == S_DONE) && !i_abort;
        o_count     = count;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            base_r   <= '0;
            len_r    <= '0;
            count    <= '0;
            issued   <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else if (i_abort && (state != S_IDLE)) begin
            state    <= S_IDLE;
            inflight <= 1'b0;
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            inflight <= o_mem_read;
            if (o_mem_read) issued <= issued + ONE;
            if (beat)       count  <= count + ONE;
            if (push_store) wr_ptr <= ~wr_ptr;
            if (pop_fifo)   rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push_store} - {1'b0, pop_fifo};
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        base_r <= i_base;
                        len_r  <= i_len;
                        count  <= '0;
                        issued <= '0;
                        if (i_len == '0)  state <= S_DONE;
                        else if (i_mode)  state <= S_RD;
                        else              state <= S_WR;
                    end
                end
                S_WR: begin
                    if (o_mem_write && ((count + ONE) == len_r)) state <= S_DONE;
                end
                S_RD: begin
                    if (o_mem_read && ((issued + ONE) == len_r)) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && (level == 3'd0)) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage holds data only; its validity is tracked by occ.
    always_ff @(posedge i_clk) begin
        if (push_store && !i_abort) fifo_q[wr_ptr] <= i_mem_rdata;
    end

`ifdef AIB_SRAM_DMA_CRC_EN
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    function automatic logic [31:0] crc32_word(input logic [31:0] crc_in, input logic [31:0] data);
        logic [31:0] r;
        logic        fb;
        r = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb = r[31] ^ data[i];
            r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'd0);
        end
        return r;
    endfunction

    logic [31:0] crc_q;
    logic [31:0] beat_data;

    assign beat_data = o_mem_write ? i_s_data : head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                        crc_q <= 32'd0;
        else if ((state == S_IDLE) && i_start) crc_q <= 32'hFFFF_FFFF;
        else if (beat)                       crc_q <= crc32_word(crc_q, beat_data);
    end

    assign o_crc = crc_q;
`else
    assign o_crc = 32'd0;
`endif

endmodule
